// File: rtl/coax_rx_fifo.sv
// Receive word buffer: tags coax receiver words/errors into an FWFT FIFO with sticky overflow.
// Optional almost_full output and AF_THRESHOLD parameter via COAX_RX_FIFO_ALMOST_FULL_EN.
module coax_rx_fifo #(
  parameter int unsigned DEPTH = 32
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
  , parameter int unsigned AF_THRESHOLD = DEPTH - 4
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   rx_data,
  input  logic                         rx_strobe,
  input  logic                         rx_error,
  output logic [10:0]                  rd_data,
  input  logic                         rd_en,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clear_overflow
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
  , output logic                       almost_full
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = 11;

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
  logic          almost_full_q, almost_full_d;
`endif

  logic          wr_req;
  logic          wr_ok;
  logic          rd_ok;
  logic [EW-1:0] wr_entry;

  // Accept/pop decisions and next state; a write into a full FIFO only lands when a pop frees the slot
  always_comb begin
    wr_req     = rx_strobe | rx_error;
    rd_ok      = rd_en && !empty_q;
    wr_ok      = wr_req && (!full_q || rd_en);
    wr_entry   = rx_error ? {1'b1, 6'b0, rx_data[3:0]} : {1'b0, rx_data};

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d    = (count_d == CW'(0));
    full_d     = (count_d == CW'(DEPTH));
    // Set has priority over clear so a drop coinciding with a clear is never lost
    overflow_d = (overflow_q && !clear_overflow) || (wr_req && !wr_ok);
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
    almost_full_d = (count_d >= CW'(AF_THRESHOLD));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
      almost_full_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
      almost_full_q <= almost_full_d;
`endif
    end
  end

  // Storage is not reset; writes in the reset cycle are discarded
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
`ifdef COAX_RX_FIFO_ALMOST_FULL_EN
  assign almost_full = almost_full_q;
`endif

endmodule
